// File: rtl/iterative_multiplier.sv
// iterative_multiplier: shift-add multiplier feeding the register-file write port (WE3/A3/WD3)
// Optional feature macro: SIGNED_MUL_EN (two's-complement mode when latched SIGNED=1)
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   START                 request, sampled only in IDLE
//   SRC_A, SRC_B          multiplicand / multiplier
//   DEST                  destination register for the low product word
//   SIGNED                two's-complement request (ignored without SIGNED_MUL_EN)
//   BUSY                  high in RUN and WB
//   DONE, WE3             one-cycle pulse in WB
//   A3, WD3               write address / low product word
//   PROD_HI               high product word
module iterative_multiplier #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [WIDTH-1:0]  SRC_A,
    input  logic [WIDTH-1:0]  SRC_B,
    input  logic [ADDR_W-1:0] DEST,
    input  logic              SIGNED,
    output logic              BUSY,
    output logic              DONE,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [WIDTH-1:0]  WD3,
    output logic [WIDTH-1:0]  PROD_HI
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0]  dest_q, dest_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   wd3_q, wd3_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               sen;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step, prod;
`ifdef SIGNED_MUL_EN
    assign sen = SIGNED;
`else
    logic unused_signed;
    assign unused_signed = SIGNED;
    assign sen = 1'b0;
`endif
    assign mag_a = (sen && SRC_A[WIDTH-1]) ? -SRC_A : SRC_A;
    assign mag_b = (sen && SRC_B[WIDTH-1]) ? -SRC_B : SRC_B;
    // Upper half accumulates with carry; the multiplier lives in the lower half and shifts out.
    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step = {sum, acc_q[WIDTH-1:1]};
    // Sign fix-up is applied as the last iteration lands so WB already presents the final value.
    assign prod = neg_q ? -acc_step : acc_step;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        dest_d  = dest_q;
        neg_d   = neg_q;
        wd3_d   = wd3_q;
        hi_d    = hi_q;
        case (state_q)
            IDLE: if (START) begin
                state_d = RUN;
                cnt_d   = '0;
                mcand_d = mag_a;
                acc_d   = {{WIDTH{1'b0}}, mag_b};
                dest_d  = DEST;
                neg_d   = sen & (SRC_A[WIDTH-1] ^ SRC_B[WIDTH-1]);
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = WB;
                    wd3_d   = prod[WIDTH-1:0];
                    hi_d    = prod[2*WIDTH-1:WIDTH];
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            dest_q  <= '0;
            neg_q   <= 1'b0;
            wd3_q   <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            dest_q  <= dest_d;
            neg_q   <= neg_d;
            wd3_q   <= wd3_d;
            hi_q    <= hi_d;
        end
    end
    assign BUSY    = state_q != IDLE;
    assign WE3     = state_q == WB;
    assign DONE    = WE3;
    assign A3      = dest_q;
    assign WD3     = wd3_q;
    assign PROD_HI = hi_q;
endmodule

// File: tb/tb_iterative_multiplier.sv
// tb_iterative_multiplier: directed self-checking bench for iterative_multiplier
module tb_iterative_multiplier;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        SIGNED = 1'b0;
    logic [31:0] SRC_A = '0;
    logic [31:0] SRC_B = '0;
    logic [4:0]  DEST = '0;
    logic        BUSY, DONE, WE3;
    logic [4:0]  A3;
    logic [31:0] WD3, PROD_HI;
    int errors = 0;
    int checks = 0;
    iterative_multiplier dut (
        .CLK(CLK), .RESET(RESET), .START(START), .SRC_A(SRC_A), .SRC_B(SRC_B),
        .DEST(DEST), .SIGNED(SIGNED), .BUSY(BUSY), .DONE(DONE), .WE3(WE3),
        .A3(A3), .WD3(WD3), .PROD_HI(PROD_HI)
    );
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic start_job(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d, input logic s);
        @(negedge CLK);
        SRC_A = a; SRC_B = b; DEST = d; SIGNED = s; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0; SRC_A = ~a; SRC_B = ~b; DEST = ~d; SIGNED = ~s;
    endtask
    task automatic wait_wb(input string tag, input int lat);
        int n = 0;
        logic all_busy = 1'b1;
        @(negedge CLK);
        while (!WE3 && n < 100) begin
            all_busy &= BUSY;
            n++;
            @(negedge CLK);
        end
        check({tag, "_seen"}, 64'(WE3), 64'd1);
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_busy"}, 64'(all_busy), 64'd1);
    endtask
    task automatic check_wb(input string tag, input logic [4:0] d, input logic [31:0] lo, input logic [31:0] hi);
        check({tag, "_done"}, 64'(DONE), 64'd1);
        check({tag, "_busy_wb"}, 64'(BUSY), 64'd1);
        check({tag, "_a3"}, 64'(A3), 64'(d));
        check({tag, "_wd3"}, 64'(WD3), 64'(lo));
        check({tag, "_hi"}, 64'(PROD_HI), 64'(hi));
    endtask
    task automatic count_writes(input string tag, input int cycles);
        int w = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (WE3) w++;
        end
        check(tag, 64'(w), 64'd0);
    endtask
    initial begin
        int p[3];
        int k;
        logic [31:0] exp_hi;
        repeat (2) @(negedge CLK);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_we3", 64'(WE3), 64'd0);
        check("rst_a3", 64'(A3), 64'd0);
        check("rst_wd3", 64'(WD3), 64'd0);
        check("rst_hi", 64'(PROD_HI), 64'd0);
        RESET = 1'b0;
        start_job(32'd3, 32'd5, 5'd2, 1'b0);
        wait_wb("t1", 32);
        check_wb("t1", 5'd2, 32'h0000000F, 32'h0);
        @(negedge CLK);
        check("t1_idle_busy", 64'(BUSY), 64'd0);
        check("t1_idle_we3", 64'(WE3), 64'd0);
        check("t1_hold_wd3", 64'(WD3), 64'h0F);
        start_job(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 1'b0);
        wait_wb("t2", 32);
        check_wb("t2", 5'd7, 32'h00000001, 32'hFFFFFFFE);
        start_job(32'd2, 32'd4, 5'd3, 1'b0);
        repeat (3) @(negedge CLK);
        SRC_A = 32'd9; SRC_B = 32'd9; DEST = 5'd9; START = 1'b1;
        repeat (5) @(negedge CLK);
        START = 1'b0;
        wait_wb("t3", 24);
        check_wb("t3", 5'd3, 32'h00000008, 32'h0);
        count_writes("t3_single_write", 40);
        start_job(32'd1, 32'd1, 5'd4, 1'b0);
        repeat (10) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("t4_busy", 64'(BUSY), 64'd0);
        check("t4_we3", 64'(WE3), 64'd0);
        check("t4_wd3", 64'(WD3), 64'd0);
        check("t4_a3", 64'(A3), 64'd0);
        count_writes("t4_no_write", 40);
        @(negedge CLK);
        SRC_A = 32'd5; SRC_B = 32'd5; RESET = 1'b1; START = 1'b1;
        @(negedge CLK);
        RESET = 1'b0; START = 1'b0;
        check("t4_rst_wins", 64'(BUSY), 64'd0);
        start_job(32'd6, 32'd7, 5'd5, 1'b0);
        wait_wb("t4b", 32);
        check_wb("t4b", 5'd5, 32'h0000002A, 32'h0);
        @(negedge CLK);
        SRC_A = 32'd3; SRC_B = 32'd3; DEST = 5'd1; SIGNED = 1'b0; START = 1'b1;
        k = 0;
        for (int i = 0; i < 200 && k < 3; i++) begin
            @(negedge CLK);
            if (WE3) begin
                p[k] = i;
                k++;
            end
        end
        START = 1'b0;
        check("t5_pulses", 64'(k), 64'd3);
        check("t5_gap1", 64'(p[1] - p[0]), 64'd34);
        check("t5_gap2", 64'(p[2] - p[1]), 64'd34);
        check("t5_wd3", 64'(WD3), 64'd9);
        repeat (2) @(negedge CLK);
        check("t5_idle", 64'(BUSY), 64'd0);
        start_job(32'hFFFFFFFD, 32'd5, 5'd6, 1'b1);
        wait_wb("t6", 32);
`ifdef SIGNED_MUL_EN
        exp_hi = 32'hFFFFFFFF;
`else
        exp_hi = 32'h00000004;
`endif
        check_wb("t6", 5'd6, 32'hFFFFFFF1, exp_hi);
        start_job(32'd0, 32'd0, 5'd0, 1'b0);
        wait_wb("t7", 32);
        check_wb("t7", 5'd0, 32'h0, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
